// File: rtl/std_cache_pkg.sv
// Shared types for the cache-subsystem AXI port: class encoding, ID patterns,
// default AXI channel structs and the ID-to-class decode used by AR/AW/R/B routing.
package std_cache_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;

  typedef struct packed {
    int unsigned AxiIdWidth;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{AxiIdWidth: AXI_ID_W};

  localparam logic [3:0]  AXI_ID_ICACHE     = 4'b0000;
  localparam logic [3:0]  AXI_ID_DCACHE     = 4'b0111;
  localparam int unsigned AXI_ID_BYPASS_BIT = 3;

  typedef enum logic [1:0] {
    AXI_CLS_ICACHE = 2'd0,
    AXI_CLS_BYPASS = 2'd1,
    AXI_CLS_DCACHE = 2'd2,
    AXI_CLS_NONE   = 2'd3
  } axi_cls_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
  } cache_axi_ax_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } cache_axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } cache_axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } cache_axi_r_t;

  typedef struct packed {
    cache_axi_ax_t aw;
    logic          aw_valid;
    cache_axi_w_t  w;
    logic          w_valid;
    logic          b_ready;
    cache_axi_ax_t ar;
    logic          ar_valid;
    logic          r_ready;
  } cache_axi_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    cache_axi_b_t b;
    logic         r_valid;
    cache_axi_r_t r;
  } cache_axi_rsp_t;

  function automatic axi_cls_e axi_id_to_cls(input logic [3:0] id);
    if (id[AXI_ID_BYPASS_BIT]) return AXI_CLS_BYPASS;
    if (id == AXI_ID_DCACHE)   return AXI_CLS_DCACHE;
    if (id == AXI_ID_ICACHE)   return AXI_CLS_ICACHE;
    return AXI_CLS_NONE;
  endfunction

endpackage

// File: rtl/std_cache_axi_txn_ctr.sv
// Per-class outstanding read/write counters with limit flags; optional response
// watchdog when CACHE_AXI_MON_TIMEOUT_EN is defined.
module std_cache_axi_txn_ctr #(
  parameter int unsigned MaxOutstanding = 4
`ifdef CACHE_AXI_MON_TIMEOUT_EN
  , parameter int unsigned TimeoutCycles = 1024
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rd_inc_i,
  input  logic rd_dec_i,
  input  logic wr_inc_i,
  input  logic wr_dec_i,
  output logic rd_full_o,
  output logic wr_full_o,
  output logic active_o,
  output logic underflow_o
`ifdef CACHE_AXI_MON_TIMEOUT_EN
  , output logic expire_o
`endif
);

  localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [CntW-1:0] rd_cnt_q, wr_cnt_q;

  // Simultaneous inc/dec leaves the count alone; a decrement at zero saturates.
  function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt,
                                               input logic inc, input logic dec);
    if (inc && !dec) return cnt + CntW'(1);
    if (dec && !inc && (cnt != '0)) return cnt - CntW'(1);
    return cnt;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= cnt_next(rd_cnt_q, rd_inc_i, rd_dec_i);
      wr_cnt_q <= cnt_next(wr_cnt_q, wr_inc_i, wr_dec_i);
    end
  end

  assign rd_full_o   = (rd_cnt_q == CntMax);
  assign wr_full_o   = (wr_cnt_q == CntMax);
  assign active_o    = (rd_cnt_q != '0) || (wr_cnt_q != '0);
  assign underflow_o = (rd_dec_i && (rd_cnt_q == '0)) || (wr_dec_i && (wr_cnt_q == '0));

`ifdef CACHE_AXI_MON_TIMEOUT_EN
  localparam int unsigned      WdogW    = $clog2(TimeoutCycles);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TimeoutCycles - 1);

  logic [WdogW-1:0] wdog_q;

  // Any completion for this class restarts the wait; the count parks at its last value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !active_o || rd_dec_i || wr_dec_i) begin
      wdog_q <= '0;
    end else if (wdog_q != WdogLast) begin
      wdog_q <= wdog_q + WdogW'(1);
    end
  end

  assign expire_o = active_o && (wdog_q == WdogLast);
`endif

endmodule

// File: rtl/std_cache_axi_txn_monitor.sv
// Outstanding-transaction monitor on the merged cache AXI port: per-class AR/AW
// throttling, underflow flag, optional watchdog (macro CACHE_AXI_MON_TIMEOUT_EN).
module std_cache_axi_txn_monitor
  import std_cache_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg        = cva6_cfg_empty,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 1024,
  parameter type         axi_req_t      = cache_axi_req_t,
  parameter type         axi_rsp_t      = cache_axi_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  axi_req_t   slv_req_i,
  output axi_rsp_t   slv_resp_o,
  output axi_req_t   mst_req_o,
  input  axi_rsp_t   mst_resp_i,
  output logic       busy_o,
  output logic       proto_err_o,
  output logic [2:0] timeout_o,
  input  logic       err_clr_i
);

  if (CVA6Cfg.AxiIdWidth < 4) begin : g_bad_id_w
    $error("AXI ID width must be at least 4 bits for class decode");
  end
  if (MaxOutstanding < 1) begin : g_bad_max
    $error("MaxOutstanding must be at least 1");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("TimeoutCycles must be at least 2");
  end

  function automatic logic cls_full(input axi_cls_e cls, input logic [2:0] full);
    case (cls)
      AXI_CLS_ICACHE: return full[0];
      AXI_CLS_BYPASS: return full[1];
      AXI_CLS_DCACHE: return full[2];
      default:        return 1'b0;
    endcase
  endfunction

  axi_cls_e   ar_cls, aw_cls, r_cls, b_cls;
  logic [2:0] rd_full, wr_full, cls_active, cls_underflow;
  logic       ar_gate, aw_gate;
  logic       ar_hs, aw_hs, r_done, b_done;
  logic       busy_q, proto_err_q;

  assign ar_cls = axi_id_to_cls(slv_req_i.ar.id[3:0]);
  assign aw_cls = axi_id_to_cls(slv_req_i.aw.id[3:0]);
  assign r_cls  = axi_id_to_cls(mst_resp_i.r.id[3:0]);
  assign b_cls  = axi_id_to_cls(mst_resp_i.b.id[3:0]);

  // Gating looks only at registered counts so a same-cycle completion cannot open it.
  assign ar_gate = cls_full(ar_cls, rd_full);
  assign aw_gate = cls_full(aw_cls, wr_full);

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid && !ar_gate;
    mst_req_o.aw_valid = slv_req_i.aw_valid && !aw_gate;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready && !ar_gate;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready && !aw_gate;
  end

  assign ar_hs  = slv_req_i.ar_valid && mst_resp_i.ar_ready && !ar_gate;
  assign aw_hs  = slv_req_i.aw_valid && mst_resp_i.aw_ready && !aw_gate;
  assign r_done = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
  assign b_done = mst_resp_i.b_valid && slv_req_i.b_ready;

`ifdef CACHE_AXI_MON_TIMEOUT_EN
  logic [2:0] cls_expire;
  logic [2:0] timeout_q;
`endif

  for (genvar c = 0; c < 3; c++) begin : g_cls
    localparam logic [1:0] ClsIdx = 2'(c);

    std_cache_axi_txn_ctr #(
      .MaxOutstanding (MaxOutstanding)
`ifdef CACHE_AXI_MON_TIMEOUT_EN
      , .TimeoutCycles (TimeoutCycles)
`endif
    ) u_ctr (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .rd_inc_i    (ar_hs  && (ar_cls == ClsIdx)),
      .rd_dec_i    (r_done && (r_cls  == ClsIdx)),
      .wr_inc_i    (aw_hs  && (aw_cls == ClsIdx)),
      .wr_dec_i    (b_done && (b_cls  == ClsIdx)),
      .rd_full_o   (rd_full[c]),
      .wr_full_o   (wr_full[c]),
      .active_o    (cls_active[c]),
      .underflow_o (cls_underflow[c])
`ifdef CACHE_AXI_MON_TIMEOUT_EN
      , .expire_o  (cls_expire[c])
`endif
    );
  end

  // A fresh error in the clear cycle keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      busy_q <= |cls_active;
      if (|cls_underflow) begin
        proto_err_q <= 1'b1;
      end else if (err_clr_i) begin
        proto_err_q <= 1'b0;
      end
    end
  end

  assign busy_o      = busy_q;
  assign proto_err_o = proto_err_q;

`ifdef CACHE_AXI_MON_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timeout_q <= 3'b000;
    end else begin
      timeout_q <= (timeout_q & ~{3{err_clr_i}}) | cls_expire;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 3'b000;
`endif

endmodule

// File: tb/tb_std_cache_axi_txn_monitor.sv
// Self-checking bench for std_cache_axi_txn_monitor: directed limit/underflow/reset
// scenarios plus randomized traffic against a count-per-class reference model.
`timescale 1ns/1ps
module tb_std_cache_axi_txn_monitor;
  import std_cache_pkg::*;

  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned TO_CYC  = 16;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  cache_axi_req_t slv_req, mst_req;
  cache_axi_rsp_t slv_resp, mst_resp;
  logic           busy, perr, err_clr;
  logic [2:0]     tmo;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  std_cache_axi_txn_monitor #(
    .MaxOutstanding (MAX_OUT),
    .TimeoutCycles  (TO_CYC)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .slv_req_i   (slv_req),
    .slv_resp_o  (slv_resp),
    .mst_req_o   (mst_req),
    .mst_resp_i  (mst_resp),
    .busy_o      (busy),
    .proto_err_o (perr),
    .timeout_o   (tmo),
    .err_clr_i   (err_clr)
  );

  // Reference class rule: MSB set = bypass(1), 0111 = dcache(2), 0000 = icache(0), else untracked(3).
  function automatic int ref_cls(input logic [3:0] id);
    if (id[3]) return 1;
    if (id == 4'd7) return 2;
    if (id == 4'd0) return 0;
    return 3;
  endfunction

  function automatic logic [3:0] id_for_cls(input int c);
    logic [2:0] low;
    low = 3'($urandom_range(0, 7));
    if (c == 0) return 4'd0;
    if (c == 2) return 4'd7;
    if (c == 1) return {1'b1, low};
    return ($urandom_range(0, 1) != 0) ? 4'd3 : 4'd5;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    slv_req           = '0;
    slv_req.r_ready   = 1'b1;
    slv_req.b_ready   = 1'b1;
    mst_resp          = '0;
    mst_resp.ar_ready = 1'b1;
    mst_resp.aw_ready = 1'b1;
    err_clr           = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    tick();
    tick();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'd0;
    settle();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err got %b want 0", perr); end
    n_cmp++; if (tmo !== 3'b000) begin n_fail++; $display("FAIL reset_timeout got %b want 000", tmo); end
    n_cmp++; if (mst_req.ar_valid !== 1'b1 || slv_resp.ar_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_passthru mst_ar_valid=%b ar_ready=%b want 1/1", mst_req.ar_valid, slv_resp.ar_ready);
    end
    tick();
    rst_ni = 1'b1;
    slv_req.ar_valid = 1'b0;
  endtask

  task automatic test_limit();
    do_reset();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'd0;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_cmp++; if (slv_resp.ar_ready !== (i < 4)) begin
        n_fail++; $display("FAIL limit_ar_ready[%0d] got %b want %b", i, slv_resp.ar_ready, (i < 4));
      end
      tick();
    end
    settle();
    n_cmp++; if (mst_req.ar_valid !== 1'b0) begin n_fail++; $display("FAIL limit_mst_ar_valid got %b want 0", mst_req.ar_valid); end
    tick();
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = 4'd0;
    mst_resp.r.last  = 1'b1;
    settle();
    n_cmp++; if (slv_resp.ar_ready !== 1'b0) begin n_fail++; $display("FAIL limit_same_cycle_r got %b want 0", slv_resp.ar_ready); end
    tick();
    mst_resp.r_valid = 1'b0;
    settle();
    n_cmp++; if (slv_resp.ar_ready !== 1'b1) begin n_fail++; $display("FAIL limit_after_r got %b want 1", slv_resp.ar_ready); end
    tick();
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mst_resp.r_valid = 1'b0;
    settle();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL limit_busy_lag got %b want 1", busy); end
    tick();
    settle();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL limit_busy_drained got %b want 0", busy); end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'd7;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_cmp++; if (slv_resp.ar_ready !== 1'b1) begin n_fail++; $display("FAIL simul_fill[%0d] got %b want 1", i, slv_resp.ar_ready); end
      tick();
    end
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = 4'd7;
    mst_resp.r.last  = 1'b1;
    settle();
    n_cmp++; if (slv_resp.ar_ready !== 1'b0 || mst_req.ar_valid !== 1'b0) begin
      n_fail++; $display("FAIL simul_gated ar_ready=%b mst_ar_valid=%b want 0/0", slv_resp.ar_ready, mst_req.ar_valid);
    end
    tick();
    mst_resp.r_valid = 1'b0;
    settle();
    n_cmp++; if (slv_resp.ar_ready !== 1'b1) begin n_fail++; $display("FAIL simul_refill got %b want 1", slv_resp.ar_ready); end
    tick();
    settle();
    n_cmp++; if (slv_resp.ar_ready !== 1'b0) begin n_fail++; $display("FAIL simul_next_blocked got %b want 0", slv_resp.ar_ready); end
    tick();
    slv_req.ar_valid = 1'b0;
  endtask

  task automatic test_underflow();
    do_reset();
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'b1010;
    settle();
    n_cmp++; if (perr !== 1'b0) begin n_fail++; $display("FAIL underflow_before got %b want 0", perr); end
    tick();
    mst_resp.b_valid = 1'b0;
    settle();
    n_cmp++; if (perr !== 1'b1) begin n_fail++; $display("FAIL underflow_set got %b want 1", perr); end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    n_cmp++; if (perr !== 1'b0) begin n_fail++; $display("FAIL underflow_clr got %b want 0", perr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL underflow_busy got %b want 0", busy); end
    tick();
    mst_resp.b_valid = 1'b1;
    err_clr          = 1'b1;
    tick();
    mst_resp.b_valid = 1'b0;
    err_clr          = 1'b0;
    settle();
    n_cmp++; if (perr !== 1'b1) begin n_fail++; $display("FAIL underflow_err_beats_clr got %b want 1", perr); end
    tick();
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_cmp++; if (slv_resp.aw_ready !== (i < 4)) begin
        n_fail++; $display("FAIL underflow_cnt_zero_aw[%0d] got %b want %b", i, slv_resp.aw_ready, (i < 4));
      end
      tick();
    end
    slv_req.aw_valid = 1'b0;
  endtask

  task automatic test_untracked();
    do_reset();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      settle();
      n_cmp++; if (slv_resp.ar_ready !== 1'b1 || mst_req.ar_valid !== 1'b1) begin
        n_fail++; $display("FAIL untracked[%0d] ar_ready=%b mst_ar_valid=%b want 1/1", i, slv_resp.ar_ready, mst_req.ar_valid);
      end
      tick();
    end
    slv_req.ar_valid = 1'b0;
    tick();
    settle();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL untracked_busy got %b want 0", busy); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 4'b1000;
    tick();
    slv_req.aw_valid = 1'b0;
`ifdef CACHE_AXI_MON_TIMEOUT_EN
    for (int i = 1; i < int'(TO_CYC); i++) tick();
    settle();
    n_cmp++; if (tmo !== 3'b000) begin n_fail++; $display("FAIL timeout_early got %b want 000", tmo); end
    tick();
    settle();
    n_cmp++; if (tmo !== 3'b010) begin n_fail++; $display("FAIL timeout_fire got %b want 010", tmo); end
    tick();
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'b1000;
    tick();
    mst_resp.b_valid = 1'b0;
    settle();
    n_cmp++; if (tmo !== 3'b010) begin n_fail++; $display("FAIL timeout_sticky got %b want 010", tmo); end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    n_cmp++; if (tmo !== 3'b000) begin n_fail++; $display("FAIL timeout_clr got %b want 000", tmo); end
    tick();
    for (int i = 0; i < 20; i++) tick();
    settle();
    n_cmp++; if (tmo !== 3'b000) begin n_fail++; $display("FAIL timeout_idle got %b want 000", tmo); end
    tick();
`else
    for (int i = 0; i < 20; i++) tick();
    settle();
    n_cmp++; if (tmo !== 3'b000) begin n_fail++; $display("FAIL timeout_disabled got %b want 000", tmo); end
    tick();
`endif
  endtask

  task automatic test_reset_midop();
    do_reset();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'd7;
    for (int i = 0; i < 3; i++) tick();
    slv_req.ar_valid = 1'b0;
    settle();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    slv_req.ar_valid = 1'b1;
    settle();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_cmp++; if (slv_resp.ar_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_first_ar got %b want 1", slv_resp.ar_ready); end
    tick();
    for (int i = 1; i < 5; i++) begin
      settle();
      n_cmp++; if (slv_resp.ar_ready !== (i < 4)) begin
        n_fail++; $display("FAIL midrst_refill[%0d] got %b want %b", i, slv_resp.ar_ready, (i < 4));
      end
      tick();
    end
    slv_req.ar_valid = 1'b0;
  endtask

  task automatic test_random();
    int   rd [3];
    int   wr [3];
    logic busy_m, perr_m, any_m;
    logic exp_ar_v, exp_ar_r, exp_aw_v, exp_aw_r;
    int   acls, wcls, rc, bc;
    do_reset();
    for (int c = 0; c < 3; c++) begin rd[c] = 0; wr[c] = 0; end
    busy_m = 1'b0;
    perr_m = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      slv_req.ar_valid  = 1'($urandom_range(0, 1));
      slv_req.ar.id     = id_for_cls(int'($urandom_range(0, 3)));
      slv_req.ar.addr   = $urandom;
      mst_resp.ar_ready = ($urandom_range(0, 3) != 0);
      slv_req.aw_valid  = 1'($urandom_range(0, 1));
      slv_req.aw.id     = id_for_cls(int'($urandom_range(0, 3)));
      slv_req.aw.addr   = $urandom;
      mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
      slv_req.w_valid   = 1'($urandom_range(0, 1));
      slv_req.w.data    = {$urandom, $urandom};
      slv_req.w.strb    = 8'($urandom);
      rc = int'($urandom_range(0, 3));
      mst_resp.r_valid  = (rc == 3) ? 1'($urandom_range(0, 1)) : (rd[rc] > 0);
      mst_resp.r.id     = id_for_cls(rc);
      mst_resp.r.last   = 1'($urandom_range(0, 1));
      mst_resp.r.data   = {$urandom, $urandom};
      slv_req.r_ready   = ($urandom_range(0, 3) != 0);
      bc = int'($urandom_range(0, 3));
      mst_resp.b_valid  = (bc == 3) ? 1'($urandom_range(0, 1)) : (wr[bc] > 0);
      mst_resp.b.id     = id_for_cls(bc);
      slv_req.b_ready   = ($urandom_range(0, 3) != 0);
      settle();
      acls = ref_cls(slv_req.ar.id);
      wcls = ref_cls(slv_req.aw.id);
      exp_ar_v = slv_req.ar_valid  && !(acls < 3 && rd[acls] == int'(MAX_OUT));
      exp_ar_r = mst_resp.ar_ready && !(acls < 3 && rd[acls] == int'(MAX_OUT));
      exp_aw_v = slv_req.aw_valid  && !(wcls < 3 && wr[wcls] == int'(MAX_OUT));
      exp_aw_r = mst_resp.aw_ready && !(wcls < 3 && wr[wcls] == int'(MAX_OUT));
      n_cmp++; if (mst_req.ar_valid !== exp_ar_v || slv_resp.ar_ready !== exp_ar_r) begin
        n_fail++; $display("FAIL rand_ar[%0d] v/r got %b/%b want %b/%b", cyc, mst_req.ar_valid, slv_resp.ar_ready, exp_ar_v, exp_ar_r);
      end
      n_cmp++; if (mst_req.aw_valid !== exp_aw_v || slv_resp.aw_ready !== exp_aw_r) begin
        n_fail++; $display("FAIL rand_aw[%0d] v/r got %b/%b want %b/%b", cyc, mst_req.aw_valid, slv_resp.aw_ready, exp_aw_v, exp_aw_r);
      end
      n_cmp++; if (busy !== busy_m || perr !== perr_m) begin
        n_fail++; $display("FAIL rand_flags[%0d] busy/perr got %b/%b want %b/%b", cyc, busy, perr, busy_m, perr_m);
      end
      n_cmp++; if (mst_req.w !== slv_req.w || mst_req.w_valid !== slv_req.w_valid || slv_resp.r !== mst_resp.r) begin
        n_fail++; $display("FAIL rand_passthru[%0d] w_valid got %b want %b", cyc, mst_req.w_valid, slv_req.w_valid);
      end
      any_m = 1'b0;
      for (int c = 0; c < 3; c++) if (rd[c] != 0 || wr[c] != 0) any_m = 1'b1;
      busy_m = any_m;
      if (mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last && ref_cls(mst_resp.r.id) < 3) begin
        if (rd[ref_cls(mst_resp.r.id)] == 0) perr_m = 1'b1;
        else rd[ref_cls(mst_resp.r.id)]--;
      end
      if (mst_resp.b_valid && slv_req.b_ready && ref_cls(mst_resp.b.id) < 3) begin
        if (wr[ref_cls(mst_resp.b.id)] == 0) perr_m = 1'b1;
        else wr[ref_cls(mst_resp.b.id)]--;
      end
      if (exp_ar_v && mst_resp.ar_ready && acls < 3) rd[acls]++;
      if (exp_aw_v && mst_resp.aw_ready && wcls < 3) wr[wcls]++;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_limit();
    test_simultaneous();
    test_underflow();
    test_untracked();
    test_timeout();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
